mem_port_arbiter: RTL

//  Shares the CPU's single SRAM-like memory port between instruction fetch (IF) and data access (MEM).

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a single two-phase (addr_ok/data_ok) memory port; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [AW-1:0]     inst_addr,
    output logic [DW-1:0]     inst_rdata,
    output logic              inst_done,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [DW/8-1:0]   data_wstrb,
    input  logic [AW-1:0]     data_addr,
    input  logic [DW-1:0]     data_wdata,
    output logic [DW-1:0]     data_rdata,
    output logic              data_done,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [DW/8-1:0]   bus_wstrb,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DW-1:0]     bus_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    logic [1:0]      state;
    logic            owner;
    logic            wr_q;
    logic [1:0]      size_q;
    logic [DW/8-1:0] wstrb_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            inst_done_q;
    logic            data_done_q;

    logic            inst_elig;
    logic            data_elig;
    logic            grant_any;
    logic            grant_mem;

    // A requester completing this cycle still holds req for one more cycle; keep it out of arbitration
    assign inst_elig = inst_req & ~inst_done_q;
    assign data_elig = data_req & ~data_done_q;
    assign grant_any = inst_elig | data_elig;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // On a tie, the side that did not win last time gets the port
    assign grant_mem = data_elig & (~inst_elig | (last_grant == OWN_IF));

    // Remember the owner of every grant so ties alternate
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= OWN_IF;
        end else if (state == ST_IDLE && grant_any) begin
            last_grant <= grant_mem;
        end
    end
`else
    // Fixed priority: MEM wins every tie
    assign grant_mem = data_elig;
`endif

    // Transaction FSM: latch the winner in IDLE, hold the address phase, collect data and pulse done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            wstrb_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner <= grant_mem;
                        state <= ST_ADDR;
                        if (grant_mem) begin
                            wr_q    <= data_wr;
                            size_q  <= data_size;
                            wstrb_q <= data_wr ? data_wstrb : '0;
                            addr_q  <= data_addr;
                            wdata_q <= data_wdata;
                        end else begin
                            wr_q    <= 1'b0;
                            size_q  <= 2'd2;
                            wstrb_q <= '0;
                            addr_q  <= inst_addr;
                            wdata_q <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus_addr_ok) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus_data_ok) begin
                        rdata_q <= bus_rdata;
                        state   <= ST_IDLE;
                        if (owner == OWN_MEM) begin
                            data_done_q <= 1'b1;
                        end else begin
                            inst_done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus_req      = (state == ST_ADDR);
    assign bus_wr       = wr_q;
    assign bus_size     = size_q;
    assign bus_wstrb    = wstrb_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;

    assign inst_done    = inst_done_q;
    assign data_done    = data_done_q;
    assign inst_rdata   = rdata_q;
    assign data_rdata   = rdata_q;

    assign stallreq_if  = inst_req & ~inst_done_q;
    assign stallreq_mem = data_req & ~data_done_q;

endmodule
